alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of per-requester grant counters (used only with ALU_ARB_STATS_EN).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  (N=0,1) operation of requester N accepted this cycle.
REQ-006 reqN_ctl  input  4  (N=0,1) ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-007 reqN_a, reqN_b  input  32  (N=0,1) operands.
REQ-008 rsp_valid  output  1  result held and valid.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  requester index owning the result.
REQ-011 rsp_result  output  32  registered ALU result.
REQ-012 rsp_zero  output  1  registered zero flag (result == 0).
REQ-013 grant_cnt0, grant_cnt1  output  CNT_W  accepted-operation counts (present only with ALU_ARB_STATS_EN).

Function
REQ-014 Block SHALL share one 32-bit ALU between two requesters; at most one operation accepted per cycle.
REQ-015 FSM states: IDLE (no result held), HOLD (result held, rsp_valid=1).
REQ-016 Acceptance possible when state=IDLE, or state=HOLD and rsp_ready=1 (same-cycle drain and refill).
REQ-017 Only one reqN_valid high and acceptance possible -> that requester granted.
REQ-018 Both valid and acceptance possible -> grant to requester not granted last (round-robin via last_grant bit).
REQ-019 reqN_ready SHALL be combinational: high only for the granted requester in the accepting cycle; never both high.
REQ-020 Operation accepted in cycle T -> rsp_valid, rsp_result, rsp_zero, rsp_id valid from cycle T+1 (latency 1).
REQ-021 Result, zero and id SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-022 Transitions: IDLE->HOLD on accept; HOLD->IDLE on rsp_ready with no accept; HOLD->HOLD on no rsp_ready, or rsp_ready with accept (new result loaded).
REQ-023 ADD/SUB SHALL wrap modulo 2^32; SLT SHALL be signed and overflow-corrected (result 1 or 0).
REQ-024 Undefined ctl codes SHALL produce result 0.
REQ-025 No reqN_valid while IDLE -> stay IDLE, all ready low.
REQ-026 last_grant SHALL update only on an accept.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, last_grant 1 (req0 wins first contention), counters 0.
REQ-028 Reset mid-HOLD SHALL discard held result; no response issued after release.
REQ-029 reqN_ready SHALL be 0 while rst_n low.

Configuration
REQ-030 Macro ALU_ARB_STATS_EN defined: grant_cnt0/1 ports present; each increments by 1 per accept of its requester, wrapping at 2^CNT_W.
REQ-031 Macro undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-032 Shared package SHALL hold ALU control-code constants, state encoding (IDLE, HOLD) and 32-bit data width constant.
REQ-033 Datapath SHALL be one sub-module, alu_core (combinational 32-bit ALU: ctl, a, b -> result, zero), instantiated once after the grant mux.

Verification
REQ-034 req0 ADD a=0x00000005 b=0x00000003, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, result 0x00000008, zero=0, id=0.
REQ-035 Both valid after reset, SUB 7-7 on req0, OR 0xF0|0x0F on req1, rsp_ready=1 -> req0 first (result 0, zero=1), req1 next cycle (0x000000FF, id=1).
REQ-036 req1 SLT a=0xFFFFFFFF b=0x00000001, rsp_ready=0 for 3 cycles -> result 0x00000001 held stable, no further ready; accept resumes when rsp_ready=1.
REQ-037 ADD 0x7FFFFFFF+1 -> 0x80000000; SLT a=0x80000000 b=0x7FFFFFFF -> 0x00000001 (overflow-corrected).
REQ-038 rst_n low during HOLD -> rsp_valid 0 immediately; after release first contention granted to req0.
REQ-039 With ALU_ARB_STATS_EN, CNT_W=4, 17 req0 accepts -> grant_cnt0=1, grant_cnt1=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter.
// ALU control codes, FSM state encoding and datapath width.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/alu_arbiter_core.sv
// Combinational 32-bit ALU shared by both requesters.
// Unknown control codes yield zero.
module alu_core
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]        ctl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic w_lt;

  // signed compare is immune to the subtract-overflow trap
  assign w_lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (ctl)
      CTL_AND: result = a & b;
      CTL_OR:  result = a | b;
      CTL_ADD: result = a + b;
      CTL_SUB: result = a - b;
      CTL_SLT: result = {{(DATA_W-1){1'b0}}, w_lt};
      CTL_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Define ALU_ARB_STATS_EN to add per-requester grant counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_ctl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_ctl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_id;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;

  logic              w_can_acc;
  logic              w_g0;
  logic              w_g1;
  logic              w_acc;
  logic [3:0]        w_ctl;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_res;
  logic              w_zero;

  // HOLD can refill in the same cycle it drains
  assign w_can_acc = rst_n &
    ((r_state == ST_IDLE) | rsp_ready);

  // last_grant=1 means req1 went last, so req0 wins a tie
  assign w_g0 = w_can_acc & req0_valid &
    (~req1_valid | r_last_grant);
  assign w_g1 = w_can_acc & req1_valid &
    (~req0_valid | ~r_last_grant);
  assign w_acc = w_g0 | w_g1;

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;

  assign w_ctl = w_g1 ? req1_ctl : req0_ctl;
  assign w_a   = w_g1 ? req1_a   : req0_a;
  assign w_b   = w_g1 ? req1_b   : req0_b;

  alu_core u_alu (
    .ctl    (w_ctl),
    .a      (w_a),
    .b      (w_b),
    .result (w_res),
    .zero   (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_state      <= ST_HOLD;
            r_result     <= w_res;
            r_zero       <= w_zero;
            r_id         <= w_g1;
            r_last_grant <= w_g1;
          end
        end
        ST_HOLD: begin
          if (w_acc) begin
            r_result     <= w_res;
            r_zero       <= w_zero;
            r_id         <= w_g1;
            r_last_grant <= w_g1;
          end else if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid  = (r_state == ST_HOLD);
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_g0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_g1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter.
// Counter checks run when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

`ifdef ALU_ARB_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctl, req1_ctl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_ctl   (req0_ctl),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_ctl   (req1_ctl),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [3:0] c,
                      input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_ctl = c; req0_a = a; req0_b = b;
  endtask

  task automatic drv1(input logic v, input logic [3:0] c,
                      input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_ctl = c; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #3;
    tick();
    rst_n = 1;
    #1;
  endtask

  initial begin
    rst_n = 0;
    rsp_ready = 0;
    drv0(1, CTL_ADD, 32'd1, 32'd1);
    drv1(1, CTL_ADD, 32'd2, 32'd2);
    #2;
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero", {31'b0, rsp_zero}, 0);
    chk("rst_id", {31'b0, rsp_id}, 0);
    chk("rst_rdy0", {31'b0, req0_ready}, 0);
    chk("rst_rdy1", {31'b0, req1_ready}, 0);
    tick();
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    rst_n = 1;
    #1;
    chk("idle_rdy0", {31'b0, req0_ready}, 0);
    tick();
    chk("idle_valid", {31'b0, rsp_valid}, 0);

    // single ADD
    rsp_ready = 1;
    drv0(1, CTL_ADD, 32'h5, 32'h3);
    #1;
    chk("add_rdy0", {31'b0, req0_ready}, 1);
    chk("add_rdy1", {31'b0, req1_ready}, 0);
    tick();
    drv0(0, 0, 0, 0);
    chk("add_valid", {31'b0, rsp_valid}, 1);
    chk("add_res", rsp_result, 32'h8);
    chk("add_zero", {31'b0, rsp_zero}, 0);
    chk("add_id", {31'b0, rsp_id}, 0);
    tick();
    chk("drain_valid", {31'b0, rsp_valid}, 0);

    // contention after reset
    do_reset();
    rsp_ready = 1;
    drv0(1, CTL_SUB, 32'h7, 32'h7);
    drv1(1, CTL_OR, 32'hF0, 32'h0F);
    #1;
    chk("rr_rdy0", {31'b0, req0_ready}, 1);
    chk("rr_rdy1", {31'b0, req1_ready}, 0);
    tick();
    drv0(0, 0, 0, 0);
    chk("sub_res", rsp_result, 0);
    chk("sub_zero", {31'b0, rsp_zero}, 1);
    chk("sub_id", {31'b0, rsp_id}, 0);
    chk("refill_rdy1", {31'b0, req1_ready}, 1);
    tick();
    drv1(0, 0, 0, 0);
    chk("or_valid", {31'b0, rsp_valid}, 1);
    chk("or_res", rsp_result, 32'hFF);
    chk("or_id", {31'b0, rsp_id}, 1);
    chk("or_zero", {31'b0, rsp_zero}, 0);
    tick();

    // SLT held under backpressure
    drv1(1, CTL_SLT, 32'hFFFFFFFF, 32'h1);
    rsp_ready = 0;
    #1;
    chk("slt_rdy1", {31'b0, req1_ready}, 1);
    tick();
    drv1(1, CTL_ADD, 32'h1, 32'h1);
    drv0(1, CTL_ADD, 32'h7FFFFFFF, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy0", {31'b0, req0_ready}, 0);
      chk("bp_rdy1", {31'b0, req1_ready}, 0);
      chk("bp_res", rsp_result, 32'h1);
      chk("bp_id", {31'b0, rsp_id}, 1);
      chk("bp_valid", {31'b0, rsp_valid}, 1);
      tick();
    end
    rsp_ready = 1;
    #1;
    chk("resume_rdy0", {31'b0, req0_ready}, 1);
    chk("resume_rdy1", {31'b0, req1_ready}, 0);
    tick();
    drv0(0, 0, 0, 0);
    drv1(1, CTL_SLT, 32'h80000000, 32'h7FFFFFFF);
    chk("ovf_add", rsp_result, 32'h80000000);
    chk("ovf_id", {31'b0, rsp_id}, 0);
    tick();
    drv1(0, 0, 0, 0);
    chk("slt_ovf", rsp_result, 32'h1);
    chk("slt_id", {31'b0, rsp_id}, 1);

    // remaining ops and undefined code
    drv0(1, CTL_NOR, 32'h0, 32'h0);
    tick();
    chk("nor", rsp_result, 32'hFFFFFFFF);
    drv0(1, CTL_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    tick();
    chk("and", rsp_result, 32'h00F0_1200);
    drv0(1, 4'b0011, 32'h1234, 32'h5678);
    tick();
    chk("undef_res", rsp_result, 0);
    chk("undef_zero", {31'b0, rsp_zero}, 1);
    drv0(1, CTL_SUB, 32'h0, 32'h1);
    tick();
    drv0(0, 0, 0, 0);
    chk("sub_wrap", rsp_result, 32'hFFFFFFFF);

    // reset while holding
    rsp_ready = 0;
    #2;
    rst_n = 0;
    drv0(1, CTL_ADD, 32'h1, 32'h2);
    drv1(1, CTL_ADD, 32'h3, 32'h4);
    #1;
    chk("hrst_valid", {31'b0, rsp_valid}, 0);
    chk("hrst_rdy0", {31'b0, req0_ready}, 0);
    chk("hrst_res", rsp_result, 0);
    tick();
    rst_n = 1;
    #1;
    chk("post_rdy0", {31'b0, req0_ready}, 1);
    chk("post_rdy1", {31'b0, req1_ready}, 0);
    tick();
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    chk("post_res", rsp_result, 32'h3);

`ifdef ALU_ARB_STATS_EN
    do_reset();
    rsp_ready = 1;
    drv0(1, CTL_ADD, 32'h1, 32'h1);
    for (int i = 0; i < 17; i++) tick();
    drv0(0, 0, 0, 0);
    chk("cnt0", {{(32-CW){1'b0}}, grant_cnt0}, 32'h1);
    chk("cnt1", {{(32-CW){1'b0}}, grant_cnt1}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
